mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single data-memory port between two cache controllers (R0 = instruction-side, R1 = data-side).
//  Each side uses the cache-style level handshake: Start held high, Finish returned.
//  The block serialises transactions, routes address/data, and returns Finish/ReadData to the owner.
//  A watchdog aborts transactions the memory never completes.
// PARAMETERS
//  AW          32    address width
//  DW          32    data width
//  RR_EN       1     1: round-robin between R0/R1; 0: fixed priority, R1 wins
//  TIMEOUT     1023  max cycles in READ/WRITE before abort; 0 disables watchdog
// PORTS
//  CLK            in   1   clock, rising edge
//  RESET          in   1   asynchronous, active-high reset
//  R0ReadStart    in   1   R0 read request (level)
//  R0WriteStart   in   1   R0 write request (level)
//  R0Addr         in   AW  R0 address
//  R0WriteData    in   DW  R0 write data
//  R0ReadData     out  DW  read data returned to R0
//  R0ReadFinish   out  1   1-cycle pulse: R0 read complete
//  R0WriteFinish  out  1   1-cycle pulse: R0 write complete
//  R1*            -    -   identical set for requester R1
//  MemReadStart   out  1   to memory, held until MemReadFinish
//  MemWriteStart  out  1   to memory, held until MemWriteFinish
//  MemReadAddr    out  AW  memory read address
//  MemWriteAddr   out  AW  memory write address
//  MemWriteData   out  DW  memory write data
//  MemReadData    in   DW  memory read data, valid with MemReadFinish
//  MemReadFinish  in   1   memory read done
//  MemWriteFinish in   1   memory write done
//  Owner          out  1   requester currently/last granted
//  Busy           out  1   1 in READ/WRITE/RESP
//  Timeout        out  1   1-cycle pulse with the aborting Finish
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, done flags 0, RR pointer = 0 (R1 preferred first), watchdog 0.
//    Reset mid-transaction drops Mem*Start immediately; no Finish is returned.
//  - Done flags: 4 flags, one per {requester, read/write}.
//    Set at that transaction's RESP; cleared when the matching Start is sampled low.
//    Eligible request = Start & ~done, so a Start held high after Finish is never re-granted.
//  - Within one requester, write before read if both are eligible.
//  - Arbitration (IDLE only): with both requesters eligible:
//    RR_EN=1 grants the one != last Owner; RR_EN=0 grants R1.
//  - States:
//    IDLE -> READ | WRITE on any eligible request. Latch Owner, address, and data into Mem* registers.
//    READ: MemReadStart=1. On MemReadFinish -> RESP. Capture MemReadData into owner's ReadData.
//    WRITE: MemWriteStart=1. On MemWriteFinish -> RESP.
//    RESP: Mem*Start=0, owner's Finish=1 for exactly this cycle, set done flag -> IDLE.
//  - Latency: eligible at cycle t -> Mem*Start high at t+1.
//    Mem finish at f -> requester Finish at f+1; next grant earliest Mem*Start at f+3.
//  - Finish of the wrong type, or any finish in IDLE/RESP: ignored.
//  - Mem addresses/data: stable from grant until the next grant.
//  - R*ReadData: holds the value until that requester's next read completes.
//  - Watchdog: counter cleared at grant, +1 per cycle in READ/WRITE.
//    When it equals TIMEOUT (nonzero) -> RESP with Finish, Timeout=1; ReadData forced to 0 on a read abort.
//  - A requester deasserting Start mid-transaction does not abort; Finish is still pulsed.
// TESTING
//  1. R0 read 0x100, memory finishes 3 cycles after start with 0xCAFEF00D
//     -> R0ReadFinish 1 cycle later, R0ReadData=0xCAFEF00D, R1 outputs 0.
//  2. R0 read + R1 write 0x200/0x12345678 raised same cycle, RR_EN=1, from reset
//     -> R1 write first, then R0 read; Owner 1 then 0.
//  3. RR_EN=0, R0 and R1 reads continuously re-raised after each Finish
//     -> R1 granted each contention; R0 only when R1 Start is low.
//  4. R1 holds ReadStart high 5 cycles past R1ReadFinish -> no second MemReadStart until R1 drops and re-raises.
//  5. TIMEOUT=8, memory never finishes R0 write
//     -> R0WriteFinish + Timeout pulse 9 cycles after grant; MemWriteStart low.
//  6. RESET asserted while in READ -> MemReadStart low asynchronously, no Finish; clean read after release.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one data-memory port between two cache controllers
//            (R0 = instruction side, R1 = data side). Each side uses a level
//            Start / pulsed Finish handshake. Transactions are serialised,
//            address/data routed to memory, and Finish/ReadData returned to
//            the owning requester. A watchdog aborts memory transactions
//            that never complete.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW       address width
//   DW       data width
//   RR_EN    1: round-robin between R0/R1, 0: fixed priority (R1 wins)
//   TIMEOUT  cycles in READ/WRITE before abort, 0 disables the watchdog
// Ports
//   CLK, RESET                     clock (rising), async active-high reset
//   R{0,1}ReadStart/WriteStart     level requests from each requester
//   R{0,1}Addr, R{0,1}WriteData    request address / write data
//   R{0,1}ReadData                 last read data returned to requester
//   R{0,1}ReadFinish/WriteFinish   one-cycle completion pulses
//   MemReadStart/MemWriteStart     held to memory until its Finish
//   MemReadAddr/MemWriteAddr       memory addresses (stable between grants)
//   MemWriteData                   memory write data
//   MemReadData/MemReadFinish      memory read response
//   MemWriteFinish                 memory write response
//   Owner                          requester currently / last granted
//   Busy                           high in READ, WRITE and RESP
//   Timeout                        pulses with a watchdog-aborted Finish
// ============================================================================
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter bit RR_EN   = 1'b1,
   parameter int TIMEOUT = 1023
) (
   input  logic          CLK,
   input  logic          RESET,

   input  logic          R0ReadStart,
   input  logic          R0WriteStart,
   input  logic [AW-1:0] R0Addr,
   input  logic [DW-1:0] R0WriteData,
   output logic [DW-1:0] R0ReadData,
   output logic          R0ReadFinish,
   output logic          R0WriteFinish,

   input  logic          R1ReadStart,
   input  logic          R1WriteStart,
   input  logic [AW-1:0] R1Addr,
   input  logic [DW-1:0] R1WriteData,
   output logic [DW-1:0] R1ReadData,
   output logic          R1ReadFinish,
   output logic          R1WriteFinish,

   output logic          MemReadStart,
   output logic          MemWriteStart,
   output logic [AW-1:0] MemReadAddr,
   output logic [AW-1:0] MemWriteAddr,
   output logic [DW-1:0] MemWriteData,
   input  logic [DW-1:0] MemReadData,
   input  logic          MemReadFinish,
   input  logic          MemWriteFinish,

   output logic          Owner,
   output logic          Busy,
   output logic          Timeout
);

   // Watchdog counter only needs to reach TIMEOUT; keep at least one bit
   // so the register is legal when the watchdog is disabled.
   localparam int              c_WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [c_WD_W-1:0] c_WD_LIMIT = c_WD_W'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_owner;
   logic                r_is_write;
   logic                r_abort;
   logic [c_WD_W-1:0]   r_wd;
   // Done flags, index {requester, is_write}: 0=R0 rd, 1=R0 wr, 2=R1 rd, 3=R1 wr
   logic [3:0]          r_done;
   logic [DW-1:0]       r_r0_rdata;
   logic [DW-1:0]       r_r1_rdata;
   logic [AW-1:0]       r_mem_raddr;
   logic [AW-1:0]       r_mem_waddr;
   logic [DW-1:0]       r_mem_wdata;

   logic [3:0]          w_start;
   logic [3:0]          w_elig;
   logic [3:0]          w_done_set;
   logic                w_req0;
   logic                w_req1;
   logic                w_pick;
   logic                w_pick_wr;
   logic                w_wd_expired;
   logic                w_grant;
   logic                w_mem_done;
   logic                w_wd_abort;
   logic [DW-1:0]       w_rdata_new;

   // ------------------------------------------------------------------------
   // Request qualification and arbitration
   // ------------------------------------------------------------------------
   assign w_start = {R1WriteStart, R1ReadStart, R0WriteStart, R0ReadStart};

   // A Start still held after its Finish is masked until it is seen low.
   assign w_elig  = w_start & ~r_done;
   assign w_req0  = |w_elig[1:0];
   assign w_req1  = |w_elig[3:2];

   // Under contention round-robin hands the port to whoever did not own it
   // last; the owner register doubles as the round-robin pointer, and its
   // reset value of 0 makes R1 the first preference.
   always_comb begin
      w_pick = w_req1;
      if (w_req0 && w_req1) begin
         w_pick = RR_EN ? ~r_owner : 1'b1;
      end
   end

   // Inside one requester a pending write goes ahead of a pending read.
   assign w_pick_wr = w_pick ? w_elig[3] : w_elig[1];

   assign w_wd_expired = (TIMEOUT != 0) && (r_wd == c_WD_LIMIT);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state and state-decoded outputs. Every output here depends on
   // registered state only, so an async reset clears Mem*Start at once.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_grant       = 1'b0;
      w_mem_done    = 1'b0;
      w_wd_abort    = 1'b0;
      MemReadStart  = 1'b0;
      MemWriteStart = 1'b0;
      R0ReadFinish  = 1'b0;
      R0WriteFinish = 1'b0;
      R1ReadFinish  = 1'b0;
      R1WriteFinish = 1'b0;
      Timeout       = 1'b0;
      Busy          = 1'b1;

      case (r_state)
         S_IDLE: begin
            Busy = 1'b0;
            if (w_req0 || w_req1) begin
               w_grant     = 1'b1;
               w_state_nxt = w_pick_wr ? S_WRITE : S_READ;
            end
         end

         S_READ: begin
            MemReadStart = 1'b1;
            // A write finish here is the wrong type and is ignored.
            if (MemReadFinish) begin
               w_mem_done  = 1'b1;
               w_state_nxt = S_RESP;
            end else if (w_wd_expired) begin
               w_wd_abort  = 1'b1;
               w_state_nxt = S_RESP;
            end
         end

         S_WRITE: begin
            MemWriteStart = 1'b1;
            if (MemWriteFinish) begin
               w_mem_done  = 1'b1;
               w_state_nxt = S_RESP;
            end else if (w_wd_expired) begin
               w_wd_abort  = 1'b1;
               w_state_nxt = S_RESP;
            end
         end

         S_RESP: begin
            w_state_nxt   = S_IDLE;
            Timeout       = r_abort;
            R0ReadFinish  = ~r_owner & ~r_is_write;
            R0WriteFinish = ~r_owner &  r_is_write;
            R1ReadFinish  =  r_owner & ~r_is_write;
            R1WriteFinish =  r_owner &  r_is_write;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Done-flag set vector: the completed transaction's flag, during RESP.
   // ------------------------------------------------------------------------
   always_comb begin
      w_done_set = 4'b0000;
      if (r_state == S_RESP) begin
         w_done_set[{r_owner, r_is_write}] = 1'b1;
      end
   end

   // Read data handed back on completion; an aborted read returns zero.
   assign w_rdata_new = w_wd_abort ? '0 : MemReadData;

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_owner     <= 1'b0;
         r_is_write  <= 1'b0;
         r_abort     <= 1'b0;
         r_wd        <= '0;
         r_done      <= 4'b0000;
         r_r0_rdata  <= '0;
         r_r1_rdata  <= '0;
         r_mem_raddr <= '0;
         r_mem_waddr <= '0;
         r_mem_wdata <= '0;
      end else begin
         // A low Start clears its flag even in the cycle it would be set,
         // so a requester that drops Start during RESP can re-raise at once.
         r_done <= (r_done | w_done_set) & w_start;

         if (w_grant) begin
            r_owner     <= w_pick;
            r_is_write  <= w_pick_wr;
            r_wd        <= '0;
            r_mem_raddr <= w_pick ? R1Addr      : R0Addr;
            r_mem_waddr <= w_pick ? R1Addr      : R0Addr;
            r_mem_wdata <= w_pick ? R1WriteData : R0WriteData;
         end else if ((r_state == S_READ) || (r_state == S_WRITE)) begin
            r_wd <= r_wd + 1'b1;
         end

         if (w_mem_done || w_wd_abort) begin
            r_abort <= w_wd_abort;
         end

         if ((w_mem_done || w_wd_abort) && !r_is_write) begin
            if (r_owner) begin
               r_r1_rdata <= w_rdata_new;
            end else begin
               r_r0_rdata <= w_rdata_new;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------------
   assign R0ReadData   = r_r0_rdata;
   assign R1ReadData   = r_r1_rdata;
   assign MemReadAddr  = r_mem_raddr;
   assign MemWriteAddr = r_mem_waddr;
   assign MemWriteData = r_mem_wdata;
   assign Owner        = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Drives one stimulus stream into two arbiters (round-robin and
//            fixed priority) and compares both against a transaction-level
//            reference every cycle, plus directed scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;

   logic          CLK   = 1'b0;
   logic          RESET = 1'b1;

   logic          r0rs = 1'b0, r0ws = 1'b0, r1rs = 1'b0, r1ws = 1'b0;
   logic [AW-1:0] r0addr = '0, r1addr = '0;
   logic [DW-1:0] r0wd = '0, r1wd = '0, mrd = '0;
   logic          mrf = 1'b0, mwf = 1'b0;

   // Index 0: RR_EN=1 instance, index 1: RR_EN=0 instance
   logic [DW-1:0] o_r0rd [2];
   logic [DW-1:0] o_r1rd [2];
   logic          o_r0rf [2], o_r0wf [2], o_r1rf [2], o_r1wf [2];
   logic          o_mrs  [2], o_mws  [2], o_own  [2], o_busy [2], o_to [2];
   logic [AW-1:0] o_mra  [2], o_mwa  [2];
   logic [DW-1:0] o_mwd  [2];

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.AW(AW), .DW(DW), .RR_EN(1'b1), .TIMEOUT(TO)) u_rr (
      .CLK(CLK), .RESET(RESET),
      .R0ReadStart(r0rs), .R0WriteStart(r0ws), .R0Addr(r0addr), .R0WriteData(r0wd),
      .R0ReadData(o_r0rd[0]), .R0ReadFinish(o_r0rf[0]), .R0WriteFinish(o_r0wf[0]),
      .R1ReadStart(r1rs), .R1WriteStart(r1ws), .R1Addr(r1addr), .R1WriteData(r1wd),
      .R1ReadData(o_r1rd[0]), .R1ReadFinish(o_r1rf[0]), .R1WriteFinish(o_r1wf[0]),
      .MemReadStart(o_mrs[0]), .MemWriteStart(o_mws[0]),
      .MemReadAddr(o_mra[0]), .MemWriteAddr(o_mwa[0]), .MemWriteData(o_mwd[0]),
      .MemReadData(mrd), .MemReadFinish(mrf), .MemWriteFinish(mwf),
      .Owner(o_own[0]), .Busy(o_busy[0]), .Timeout(o_to[0])
   );

   mem_port_arbiter #(.AW(AW), .DW(DW), .RR_EN(1'b0), .TIMEOUT(TO)) u_fp (
      .CLK(CLK), .RESET(RESET),
      .R0ReadStart(r0rs), .R0WriteStart(r0ws), .R0Addr(r0addr), .R0WriteData(r0wd),
      .R0ReadData(o_r0rd[1]), .R0ReadFinish(o_r0rf[1]), .R0WriteFinish(o_r0wf[1]),
      .R1ReadStart(r1rs), .R1WriteStart(r1ws), .R1Addr(r1addr), .R1WriteData(r1wd),
      .R1ReadData(o_r1rd[1]), .R1ReadFinish(o_r1rf[1]), .R1WriteFinish(o_r1wf[1]),
      .MemReadStart(o_mrs[1]), .MemWriteStart(o_mws[1]),
      .MemReadAddr(o_mra[1]), .MemWriteAddr(o_mwa[1]), .MemWriteData(o_mwd[1]),
      .MemReadData(mrd), .MemReadFinish(mrf), .MemWriteFinish(mwf),
      .Owner(o_own[1]), .Busy(o_busy[1]), .Timeout(o_to[1])
   );

   task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
      end
   endtask

   task automatic dchk(input string nm, input logic [63:0] a0, input logic [63:0] a1, input logic [63:0] exp);
      chk(nm, 0, a0, exp);
      chk(nm, 1, a1, exp);
   endtask

   // ------------------------------------------------------------------------
   // Reference: one in-flight transaction record per instance.
   // phase 0 = port free, 1 = memory access outstanding, 2 = answering owner
   // ------------------------------------------------------------------------
   int            m_phase [2];
   bit            m_wr    [2];
   bit            m_own   [2];
   bit            m_abort [2];
   int            m_age   [2];
   bit            m_done  [2][2][2];   // [inst][requester][is_write]
   logic [DW-1:0] m_rdata [2][2];      // [inst][requester]
   logic [AW-1:0] m_addr  [2];
   logic [DW-1:0] m_wdata [2];

   bit            s_st [2][2];
   bit            s_el [2][2];
   bit            s_w0, s_w1, s_who;

   initial forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
         for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_wr[k] = 0; m_own[k] = 0; m_abort[k] = 0; m_age[k] = 0;
            m_addr[k] = '0; m_wdata[k] = '0;
            for (int r = 0; r < 2; r++) begin
               m_rdata[k][r] = '0;
               for (int t = 0; t < 2; t++) m_done[k][r][t] = 0;
            end
         end
      end else begin
         s_st[0][0] = r0rs; s_st[0][1] = r0ws; s_st[1][0] = r1rs; s_st[1][1] = r1ws;
         for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++)
               for (int t = 0; t < 2; t++)
                  s_el[r][t] = s_st[r][t] && !m_done[k][r][t];
            for (int r = 0; r < 2; r++)
               for (int t = 0; t < 2; t++)
                  m_done[k][r][t] = (m_done[k][r][t] ||
                                     (m_phase[k] == 2 && m_own[k] == r[0] && m_wr[k] == t[0]))
                                    && s_st[r][t];
            if (m_phase[k] == 0) begin
               s_w0 = s_el[0][0] || s_el[0][1];
               s_w1 = s_el[1][0] || s_el[1][1];
               if (s_w0 || s_w1) begin
                  if (s_w0 && s_w1) s_who = (k == 0) ? !m_own[k] : 1'b1;
                  else              s_who = s_w1;
                  m_own[k]   = s_who;
                  m_wr[k]    = s_el[s_who][1];
                  m_addr[k]  = s_who ? r1addr : r0addr;
                  m_wdata[k] = s_who ? r1wd : r0wd;
                  m_age[k]   = 0;
                  m_phase[k] = 1;
               end
            end else if (m_phase[k] == 1) begin
               if (m_wr[k] ? mwf : mrf) begin
                  m_phase[k] = 2; m_abort[k] = 0;
                  if (!m_wr[k]) m_rdata[k][m_own[k]] = mrd;
               end else if (m_age[k] == TO) begin
                  m_phase[k] = 2; m_abort[k] = 1;
                  if (!m_wr[k]) m_rdata[k][m_own[k]] = '0;
               end else begin
                  m_age[k]++;
               end
            end else begin
               m_phase[k] = 0;
            end
         end
      end
   end

   // Every-cycle comparison of both instances against the reference.
   initial forever begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
         chk("MemReadStart",  k, o_mrs[k],  m_phase[k] == 1 && !m_wr[k]);
         chk("MemWriteStart", k, o_mws[k],  m_phase[k] == 1 &&  m_wr[k]);
         chk("R0ReadFinish",  k, o_r0rf[k], m_phase[k] == 2 && !m_own[k] && !m_wr[k]);
         chk("R0WriteFinish", k, o_r0wf[k], m_phase[k] == 2 && !m_own[k] &&  m_wr[k]);
         chk("R1ReadFinish",  k, o_r1rf[k], m_phase[k] == 2 &&  m_own[k] && !m_wr[k]);
         chk("R1WriteFinish", k, o_r1wf[k], m_phase[k] == 2 &&  m_own[k] &&  m_wr[k]);
         chk("Timeout",       k, o_to[k],   m_phase[k] == 2 && m_abort[k]);
         chk("Busy",          k, o_busy[k], m_phase[k] != 0);
         chk("Owner",         k, o_own[k],  m_own[k]);
         chk("MemReadAddr",   k, o_mra[k],  m_addr[k]);
         chk("MemWriteAddr",  k, o_mwa[k],  m_addr[k]);
         chk("MemWriteData",  k, o_mwd[k],  m_wdata[k]);
         chk("R0ReadData",    k, o_r0rd[k], m_rdata[k][0]);
         chk("R1ReadData",    k, o_r1rd[k], m_rdata[k][1]);
      end
   end

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_reset();
      {r0rs, r0ws, r1rs, r1ws, mrf, mwf} = '0;
      RESET = 1'b1;
      step();
      step();
      RESET = 1'b0;
   endtask

   initial begin
      do_reset();
      dchk("rst_busy",  o_busy[0], o_busy[1], 0);
      dchk("rst_owner", o_own[0],  o_own[1],  0);
      dchk("rst_rdata", o_r0rd[0], o_r0rd[1], 0);

      // R0 read, memory answers 3 cycles after Start
      r0rs = 1'b1; r0addr = 32'h100;
      step();
      dchk("t1_start", o_mrs[0], o_mrs[1], 1);
      dchk("t1_addr",  o_mra[0], o_mra[1], 32'h100);
      step(); step(); step();
      mrf = 1'b1; mrd = 32'hCAFEF00D;
      step();
      mrf = 1'b0;
      dchk("t1_finish", o_r0rf[0], o_r0rf[1], 1);
      dchk("t1_rdata",  o_r0rd[0], o_r0rd[1], 32'hCAFEF00D);
      dchk("t1_r1fin",  o_r1rf[0] | o_r1wf[0], o_r1rf[1] | o_r1wf[1], 0);
      dchk("t1_r1data", o_r1rd[0], o_r1rd[1], 0);
      step();
      dchk("t1_noregrant", o_mrs[0], o_mrs[1], 0);
      r0rs = 1'b0;
      step();

      // R0 read + R1 write raised together from reset
      do_reset();
      r0rs = 1'b1; r0addr = 32'h300;
      r1ws = 1'b1; r1addr = 32'h200; r1wd = 32'h12345678;
      step();
      dchk("t2_wstart", o_mws[0], o_mws[1], 1);
      dchk("t2_own1",   o_own[0], o_own[1], 1);
      dchk("t2_waddr",  o_mwa[0], o_mwa[1], 32'h200);
      dchk("t2_wdata",  o_mwd[0], o_mwd[1], 32'h12345678);
      mwf = 1'b1;
      step();
      mwf = 1'b0;
      dchk("t2_wfin", o_r1wf[0], o_r1wf[1], 1);
      step();
      step();
      dchk("t2_rstart", o_mrs[0], o_mrs[1], 1);
      dchk("t2_own0",   o_own[0], o_own[1], 0);
      dchk("t2_raddr",  o_mra[0], o_mra[1], 32'h300);
      mrf = 1'b1; mrd = 32'h0BADBEEF;
      step();
      mrf = 1'b0;
      dchk("t2_rfin", o_r0rf[0], o_r0rf[1], 1);
      r0rs = 1'b0; r1ws = 1'b0;
      step();

      // Contention after R1 was served: round-robin turns to R0, fixed keeps R1
      do_reset();
      r0rs = 1'b1; r1rs = 1'b1;
      step();
      dchk("t3_first", o_own[0], o_own[1], 1);
      mrf = 1'b1; mrd = 32'h11;
      step();
      mrf = 1'b0; r0rs = 1'b0; r1rs = 1'b0;
      step();
      r0rs = 1'b1; r1rs = 1'b1;
      step();
      chk("t3_rr_own", 0, o_own[0], 0);
      chk("t3_fp_own", 1, o_own[1], 1);
      mrf = 1'b1;
      step();
      mrf = 1'b0; r0rs = 1'b0; r1rs = 1'b0;
      step();

      // R1 keeps ReadStart high after Finish
      do_reset();
      r1rs = 1'b1; r1addr = 32'h440;
      step();
      mrf = 1'b1; mrd = 32'h44;
      step();
      mrf = 1'b0;
      dchk("t4_fin", o_r1rf[0], o_r1rf[1], 1);
      for (int i = 0; i < 5; i++) begin
         step();
         dchk("t4_hold", o_mrs[0], o_mrs[1], 0);
      end
      r1rs = 1'b0;
      step();
      r1rs = 1'b1;
      step();
      dchk("t4_regrant", o_mrs[0], o_mrs[1], 1);
      mrf = 1'b1;
      step();
      mrf = 1'b0; r1rs = 1'b0;
      step();

      // Watchdog on a write, then on a read
      do_reset();
      r0ws = 1'b1; r0addr = 32'h500; r0wd = 32'h55;
      step();
      dchk("t5_wstart", o_mws[0], o_mws[1], 1);
      for (int i = 0; i < 8; i++) begin
         step();
         dchk("t5_wait", o_mws[0] & ~o_r0wf[0], o_mws[1] & ~o_r0wf[1], 1);
      end
      step();
      dchk("t5_wfin",  o_r0wf[0], o_r0wf[1], 1);
      dchk("t5_to",    o_to[0],   o_to[1],   1);
      dchk("t5_mwlow", o_mws[0],  o_mws[1],  0);
      r0ws = 1'b0;
      step();
      dchk("t5_topulse", o_to[0], o_to[1], 0);
      r0rs = 1'b1;
      step();
      mrf = 1'b1; mrd = 32'h77;
      step();
      mrf = 1'b0; r0rs = 1'b0;
      dchk("t5_rd77", o_r0rd[0], o_r0rd[1], 32'h77);
      step();
      r0rs = 1'b1;
      step();
      for (int i = 0; i < 9; i++) step();
      dchk("t5_rto",   o_to[0],   o_to[1],   1);
      dchk("t5_rfin",  o_r0rf[0], o_r0rf[1], 1);
      dchk("t5_rzero", o_r0rd[0], o_r0rd[1], 0);
      r0rs = 1'b0;
      step();

      // Reset in the middle of a read
      do_reset();
      r0rs = 1'b1; r0addr = 32'h600;
      step();
      dchk("t6_start", o_mrs[0], o_mrs[1], 1);
      #1 RESET = 1'b1;
      #1;
      dchk("t6_async",  o_mrs[0],  o_mrs[1],  0);
      dchk("t6_nofin",  o_r0rf[0], o_r0rf[1], 0);
      step();
      RESET = 1'b0;
      step();
      dchk("t6_again", o_mrs[0], o_mrs[1], 1);
      dchk("t6_addr",  o_mra[0], o_mra[1], 32'h600);
      mrf = 1'b1; mrd = 32'h66;
      step();
      mrf = 1'b0;
      dchk("t6_fin",   o_r0rf[0], o_r0rf[1], 1);
      dchk("t6_rdata", o_r0rd[0], o_r0rd[1], 32'h66);
      r0rs = 1'b0;
      step();

      // Randomised traffic, including stray finishes and occasional resets
      for (int n = 0; n < 4000; n++) begin
         step();
         if (RESET) RESET = 1'b0;
         else if ($urandom_range(499) == 0) RESET = 1'b1;
         if ($urandom_range(7) == 0) r0rs = ~r0rs;
         if ($urandom_range(7) == 0) r0ws = ~r0ws;
         if ($urandom_range(7) == 0) r1rs = ~r1rs;
         if ($urandom_range(7) == 0) r1ws = ~r1ws;
         r0addr = $urandom; r1addr = $urandom;
         r0wd   = $urandom; r1wd   = $urandom;
         mrd    = $urandom;
         mrf    = ($urandom_range(5) == 0);
         mwf    = ($urandom_range(5) == 0);
      end
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
